// File: rtl/useq_control_store_if.sv
// Load bus for the writable control store and opcode map RAM.
// The loader (testbench or host) drives it; the sequencer only observes it.
interface useq_control_store_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 26
);
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (output wr_en, wr_sel, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_sel, wr_addr, wr_data);
endinterface

// File: rtl/useq_control_store.sv
// Microprogram sequencer with a writable control store and opcode map RAM.
// Presents one registered microword per clock to the stack-machine datapath.
module useq_control_store #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 301,
  parameter int CTRL_W = 10,
  parameter int OPC_W  = 8,
  parameter int STK_D  = 4,
  localparam int WORD_W = CTRL_W + 6 + ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                stall,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                flag_z,
  input  logic                flag_n,
  input  logic                flag_c,
  input  logic                flag_v,
  input  logic                err_clr,
  useq_control_store_if.slave ld,
  output logic [WORD_W-1:0]   uword,
  output logic [CTRL_W-1:0]   ctrl,
  output logic                uword_valid,
  output logic [ADDR_W-1:0]   upc,
  output logic                fetch_start,
  output logic                wide_active,
  output logic                stk_ovf,
  output logic                stk_unf,
  output logic                addr_err,
  output logic                wr_err
);

  localparam logic [1:0] ST_HALT  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [2:0] SEQ_BR    = 3'd1;
  localparam logic [2:0] SEQ_JMP   = 3'd2;
  localparam logic [2:0] SEQ_CALL  = 3'd3;
  localparam logic [2:0] SEQ_RET   = 3'd4;
  localparam logic [2:0] SEQ_FETCH = 3'd6;
  localparam logic [2:0] SEQ_MAP   = 3'd7;

  localparam int SA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SP_W  = $clog2(STK_D + 1);
  localparam int MAP_N = 2 ** (OPC_W + 1);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [SP_W-1:0]   STK_FULL = SP_W'(STK_D);

  logic [WORD_W-1:0] store   [DEPTH];
  logic [ADDR_W-1:0] map_ram [MAP_N];
  // Sized to a power of two so the stack pointer indexes it without truncation.
  logic [ADDR_W-1:0] stk     [2**SP_W];

  logic [SP_W-1:0]   sp;
  logic [1:0]        state;

  logic [2:0]        seq;
  logic [2:0]        cond;
  logic [ADDR_W-1:0] next_f;
  logic              cond_true;
  logic [ADDR_W-1:0] upc_inc;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty;
  logic              stk_full;

  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] nxt;
  logic              addr_bad;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;
  logic              map_take;
  logic              fetch_take;
  logic              advance;

  logic              wr_halt;
  logic              wr_addr_ok;
  logic              store_we;
  logic              map_we;
  logic              wr_err_set;

  assign seq    = uword[ADDR_W+5 -: 3];
  assign cond   = uword[ADDR_W+2 -: 3];
  assign next_f = uword[ADDR_W-1:0];
  assign ctrl   = uword[WORD_W-1 -: CTRL_W];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'd0:    cond_true = flag_z;
      3'd1:    cond_true = flag_n;
      3'd2:    cond_true = flag_c;
      3'd3:    cond_true = flag_v;
      3'd4:    cond_true = !flag_z;
      3'd5:    cond_true = !flag_n;
      3'd6:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Sequential increment wraps at the end of the store without flagging an error.
  assign upc_inc   = (upc == LAST) ? '0 : upc + ADDR_W'(1);
  assign stk_top   = stk[sp - SP_W'(1)];
  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == STK_FULL);
  assign advance   = (state == ST_RUN) && run && !stall;

  always_comb begin
    target     = upc_inc;
    push       = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    map_take   = 1'b0;
    fetch_take = 1'b0;
    case (seq)
      SEQ_BR:    if (cond_true) target = next_f;
      SEQ_JMP:   target = next_f;
      SEQ_CALL: begin
        target = next_f;
        if (stk_full) ovf_set = 1'b1;
        else          push    = 1'b1;
      end
      SEQ_RET: begin
        if (stk_empty) begin
          target  = '0;
          unf_set = 1'b1;
        end else begin
          target = stk_top;
          pop    = 1'b1;
        end
      end
      SEQ_FETCH: begin
        target     = '0;
        fetch_take = 1'b1;
      end
      SEQ_MAP: begin
        target   = map_ram[{wide_active, opcode}];
        map_take = 1'b1;
      end
      default: target = upc_inc;
    endcase
    addr_bad = ({1'b0, target} >= DEPTH_X);
    nxt      = addr_bad ? '0 : target;
  end

  assign wr_halt    = ld.wr_en && (state == ST_HALT);
  assign wr_addr_ok = ({1'b0, ld.wr_addr} < DEPTH_X);
  assign store_we   = wr_halt && !ld.wr_sel && wr_addr_ok;
  assign map_we     = wr_halt && ld.wr_sel;
  assign wr_err_set = ld.wr_en && ((state != ST_HALT) || (!ld.wr_sel && !wr_addr_ok));

  // Storage arrays are never reset so a loaded microprogram survives a reset.
  always_ff @(posedge clk) begin
    if (store_we) store[ld.wr_addr[SA_W-1:0]] <= ld.wr_data;
    if (map_we)   map_ram[ld.wr_addr[OPC_W:0]] <= ld.wr_data[ADDR_W-1:0];
    if (advance && push) stk[sp] <= upc_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_HALT;
      upc         <= '0;
      uword       <= '0;
      uword_valid <= 1'b0;
      sp          <= '0;
      wide_active <= 1'b0;
      fetch_start <= 1'b0;
    end else begin
      fetch_start <= 1'b0;
      case (state)
        ST_HALT: begin
          uword_valid <= 1'b0;
          if (run) state <= ST_PRIME;
        end
        ST_PRIME: begin
          uword       <= store[upc[SA_W-1:0]];
          uword_valid <= 1'b1;
          state       <= ST_RUN;
        end
        ST_RUN: begin
          if (!run) begin
            state       <= ST_HALT;
            uword_valid <= 1'b0;
          end else if (!stall) begin
            upc         <= nxt;
            uword       <= store[nxt[SA_W-1:0]];
            fetch_start <= fetch_take;
            if (push)     sp <= sp + SP_W'(1);
            else if (pop) sp <= sp - SP_W'(1);
            if (fetch_take && cond == 3'b111) wide_active <= 1'b1;
            else if (map_take)                wide_active <= 1'b0;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk_ovf  <= 1'b0;
      stk_unf  <= 1'b0;
      addr_err <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      stk_ovf  <= (advance && ovf_set)  || (stk_ovf  && !err_clr);
      stk_unf  <= (advance && unf_set)  || (stk_unf  && !err_clr);
      addr_err <= (advance && addr_bad) || (addr_err && !err_clr);
      wr_err   <= wr_err_set            || (wr_err   && !err_clr);
    end
  end

endmodule

// File: tb/tb_useq_control_store.sv
// Directed bench for useq_control_store: sequencing, wide prefix, call stack,
// stall/halt/load and asynchronous reset, each checked against hand-computed values.
module tb_useq_control_store;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 301;
  localparam int CTRL_W = 10;
  localparam int OPC_W  = 8;
  localparam int STK_D  = 4;
  localparam int WORD_W = 26;

  localparam logic [2:0] S_INC = 3'd0, S_BR = 3'd1, S_JMP = 3'd2, S_CALL = 3'd3;
  localparam logic [2:0] S_RET = 3'd4, S_FETCH = 3'd6, S_MAP = 3'd7;

  logic              clk = 1'b0;
  logic              reset;
  logic              run, stall, err_clr;
  logic [OPC_W-1:0]  opcode;
  logic              flag_z, flag_n, flag_c, flag_v;
  logic [WORD_W-1:0] uword;
  logic [CTRL_W-1:0] ctrl;
  logic              uword_valid, fetch_start, wide_active;
  logic [ADDR_W-1:0] upc;
  logic              stk_ovf, stk_unf, addr_err, wr_err;

  int errors = 0;
  int checks = 0;

  useq_control_store_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) ld ();

  useq_control_store #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CTRL_W(CTRL_W), .OPC_W(OPC_W), .STK_D(STK_D)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .opcode(opcode),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .err_clr(err_clr), .ld(ld), .uword(uword), .ctrl(ctrl),
    .uword_valid(uword_valid), .upc(upc), .fetch_start(fetch_start),
    .wide_active(wide_active), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
    .addr_err(addr_err), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] mk(input logic [9:0] c, input logic [2:0] s,
                                           input logic [2:0] k, input logic [9:0] n);
    return {c, s, k, n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    ld.wr_en = 1'b1; ld.wr_sel = 1'b0; ld.wr_addr = a; ld.wr_data = d;
    tick();
    ld.wr_en = 1'b0;
  endtask

  task automatic load_map(input logic wide, input logic [7:0] op, input logic [9:0] t);
    ld.wr_en = 1'b1; ld.wr_sel = 1'b1; ld.wr_addr = {1'b0, wide, op}; ld.wr_data = {16'd0, t};
    tick();
    ld.wr_en = 1'b0; ld.wr_sel = 1'b0;
  endtask

  task automatic restart();
    run = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic halt();
    run = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; stall = 1'b0; err_clr = 1'b0; opcode = '0;
    flag_z = 1'b0; flag_n = 1'b0; flag_c = 1'b0; flag_v = 1'b0;
    ld.wr_en = 1'b0; ld.wr_sel = 1'b0; ld.wr_addr = '0; ld.wr_data = '0;
    #1;
    checks++; if (upc !== 10'd0) begin errors++; $display("FAIL reset_upc got=%0d exp=0", upc); end
    checks++; if (uword !== 26'd0) begin errors++; $display("FAIL reset_uword got=%h exp=0", uword); end
    checks++; if ({uword_valid, fetch_start, wide_active} !== 3'b000) begin
      errors++; $display("FAIL reset_status got=%b exp=000", {uword_valid, fetch_start, wide_active}); end
    checks++; if ({stk_ovf, stk_unf, addr_err, wr_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_errs got=%b exp=0000", {stk_ovf, stk_unf, addr_err, wr_err}); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_linear();
    logic [WORD_W-1:0] w [5];
    w[0] = mk(10'h011, S_INC, 3'd6, 10'd0);
    w[1] = mk(10'h022, S_INC, 3'd6, 10'd0);
    w[2] = mk(10'h033, S_INC, 3'd6, 10'd0);
    w[3] = mk(10'h044, S_MAP, 3'd6, 10'd0);
    w[4] = mk(10'h055, S_JMP, 3'd6, 10'd4);
    restart();
    for (int i = 0; i < 5; i++) load_word(10'(i), w[i]);
    load_map(1'b0, 8'h60, 10'd4);
    opcode = 8'h60;
    run = 1'b1;
    tick();
    checks++; if (uword_valid !== 1'b0) begin errors++; $display("FAIL linear_prime_valid got=%b exp=0", uword_valid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (uword_valid !== 1'b1 || upc !== 10'(i) || uword !== w[i]) begin
        errors++; $display("FAIL linear_step%0d got v=%b upc=%0d uw=%h exp v=1 upc=%0d uw=%h", i, uword_valid, upc, uword, i, w[i]); end
    end
    checks++; if (ctrl !== 10'h055) begin errors++; $display("FAIL linear_ctrl got=%h exp=055", ctrl); end
    halt();
    checks++; if (uword_valid !== 1'b0 || upc !== 10'd4) begin
      errors++; $display("FAIL linear_halt got v=%b upc=%0d exp v=0 upc=4", uword_valid, upc); end
  endtask

  task automatic test_branch();
    restart();
    load_word(10'd0,  mk(10'h001, S_JMP, 3'd6, 10'd44));
    load_word(10'd44, mk(10'h002, S_BR,  3'd0, 10'd47));
    load_word(10'd45, mk(10'h003, S_JMP, 3'd6, 10'd45));
    load_word(10'd47, mk(10'h004, S_JMP, 3'd6, 10'd47));
    flag_z = 1'b1;
    run = 1'b1;
    repeat (4) tick();
    checks++; if (upc !== 10'd47) begin errors++; $display("FAIL branch_taken got=%0d exp=47", upc); end
    halt();
    restart();
    flag_z = 1'b0;
    run = 1'b1;
    repeat (4) tick();
    checks++; if (upc !== 10'd45) begin errors++; $display("FAIL branch_not_taken got=%0d exp=45", upc); end
    halt();
  endtask

  task automatic test_wide();
    int exp_upc [6] = '{86, 152, 0, 75, 0, 86};
    logic exp_fs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_wa [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    restart();
    load_word(10'd0,   mk(10'h100, S_MAP,   3'd6, 10'd0));
    load_word(10'd86,  mk(10'h101, S_JMP,   3'd6, 10'd152));
    load_word(10'd152, mk(10'h102, S_FETCH, 3'd7, 10'd0));
    load_word(10'd75,  mk(10'h103, S_FETCH, 3'd6, 10'd0));
    load_map(1'b0, 8'h15, 10'd86);
    load_map(1'b1, 8'h15, 10'd75);
    opcode = 8'h15;
    run = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (upc !== 10'(exp_upc[i]) || fetch_start !== exp_fs[i] || wide_active !== exp_wa[i]) begin
        errors++; $display("FAIL wide_step%0d got upc=%0d fs=%b wa=%b exp upc=%0d fs=%b wa=%b",
                           i, upc, fetch_start, wide_active, exp_upc[i], exp_fs[i], exp_wa[i]); end
    end
    halt();
  endtask

  task automatic test_call_return();
    int exp_upc [11] = '{200, 210, 220, 230, 240, 250, 231, 221, 211, 201, 0};
    restart();
    load_word(10'd0,   mk(10'h200, S_JMP,  3'd6, 10'd200));
    load_word(10'd200, mk(10'h201, S_CALL, 3'd6, 10'd210));
    load_word(10'd210, mk(10'h202, S_CALL, 3'd6, 10'd220));
    load_word(10'd220, mk(10'h203, S_CALL, 3'd6, 10'd230));
    load_word(10'd230, mk(10'h204, S_CALL, 3'd6, 10'd240));
    load_word(10'd240, mk(10'h205, S_CALL, 3'd6, 10'd250));
    load_word(10'd250, mk(10'h206, S_RET,  3'd6, 10'd0));
    load_word(10'd231, mk(10'h207, S_RET,  3'd6, 10'd0));
    load_word(10'd221, mk(10'h208, S_RET,  3'd6, 10'd0));
    load_word(10'd211, mk(10'h209, S_RET,  3'd6, 10'd0));
    load_word(10'd201, mk(10'h20a, S_RET,  3'd6, 10'd0));
    run = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++; if (upc !== 10'(exp_upc[i]) || stk_ovf !== (i >= 5) || stk_unf !== (i == 10)) begin
        errors++; $display("FAIL call_step%0d got upc=%0d ovf=%b unf=%b exp upc=%0d ovf=%b unf=%b",
                           i, upc, stk_ovf, stk_unf, exp_upc[i], i >= 5, i == 10); end
    end
    halt();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if ({stk_ovf, stk_unf} !== 2'b00) begin
      errors++; $display("FAIL call_err_clr got=%b exp=00", {stk_ovf, stk_unf}); end
  endtask

  task automatic test_stall_load();
    logic [WORD_W-1:0] w60, w62, w63, wa, wb;
    w60 = mk(10'h060, S_INC, 3'd6, 10'd0);
    w62 = mk(10'h062, S_INC, 3'd6, 10'd0);
    w63 = mk(10'h063, S_JMP, 3'd6, 10'd300);
    wa  = mk(10'h2aa, S_JMP, 3'd6, 10'd300);
    wb  = mk(10'h155, S_INC, 3'd6, 10'd0);
    restart();
    load_word(10'd0,   mk(10'h000, S_JMP, 3'd6, 10'd60));
    load_word(10'd60,  w60);
    load_word(10'd61,  mk(10'h061, S_INC, 3'd6, 10'd0));
    load_word(10'd62,  w62);
    load_word(10'd63,  w63);
    load_word(10'd300, wa);
    run = 1'b1;
    repeat (3) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (upc !== 10'd60 || uword !== w60) begin
        errors++; $display("FAIL stall_hold%0d got upc=%0d uw=%h exp upc=60 uw=%h", i, upc, uword, w60); end
    end
    stall = 1'b0;
    tick();
    checks++; if (upc !== 10'd61) begin errors++; $display("FAIL stall_release got=%0d exp=61", upc); end
    ld.wr_en = 1'b1; ld.wr_sel = 1'b0; ld.wr_addr = 10'd63; ld.wr_data = 26'h3ffffff;
    tick();
    ld.wr_en = 1'b0;
    checks++; if (wr_err !== 1'b1 || upc !== 10'd62 || uword !== w62) begin
      errors++; $display("FAIL run_write_err got err=%b upc=%0d uw=%h exp err=1 upc=62 uw=%h", wr_err, upc, uword, w62); end
    tick();
    checks++; if (upc !== 10'd63 || uword !== w63) begin
      errors++; $display("FAIL run_write_ignored got upc=%0d uw=%h exp upc=63 uw=%h", upc, uword, w63); end
    tick();
    checks++; if (upc !== 10'd300 || uword !== wa) begin
      errors++; $display("FAIL reach_300 got upc=%0d uw=%h exp upc=300 uw=%h", upc, uword, wa); end
    halt();
    err_clr = 1'b1;
    load_word(10'd300, wb);
    err_clr = 1'b0;
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL halt_write_clr got=%b exp=0", wr_err); end
    load_word(10'd301, 26'h0abcdef);
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL write_oob got=%b exp=1", wr_err); end
    run = 1'b1;
    repeat (2) tick();
    checks++; if (uword_valid !== 1'b1 || upc !== 10'd300 || uword !== wb) begin
      errors++; $display("FAIL reprime_300 got v=%b upc=%0d uw=%h exp v=1 upc=300 uw=%h", uword_valid, upc, uword, wb); end
    tick();
    checks++; if (upc !== 10'd0 || addr_err !== 1'b0) begin
      errors++; $display("FAIL wrap got upc=%0d aerr=%b exp upc=0 aerr=0", upc, addr_err); end
    halt();
  endtask

  task automatic test_addr_err();
    restart();
    load_word(10'd0,  mk(10'h000, S_JMP, 3'd6, 10'd70));
    load_word(10'd70, mk(10'h070, S_JMP, 3'd6, 10'd500));
    run = 1'b1;
    repeat (4) tick();
    checks++; if (upc !== 10'd0 || addr_err !== 1'b1) begin
      errors++; $display("FAIL addr_err got upc=%0d aerr=%b exp upc=0 aerr=1", upc, addr_err); end
    halt();
  endtask

  task automatic test_reset_mid_run();
    logic [WORD_W-1:0] w0;
    w0 = mk(10'h3c0, S_JMP, 3'd6, 10'd10);
    load_word(10'd0,  w0);
    load_word(10'd10, mk(10'h010, S_INC, 3'd6, 10'd0));
    load_word(10'd11, mk(10'h011, S_INC, 3'd6, 10'd0));
    load_word(10'd12, mk(10'h012, S_INC, 3'd6, 10'd0));
    load_word(10'd13, mk(10'h013, S_JMP, 3'd6, 10'd13));
    run = 1'b1;
    repeat (5) tick();
    checks++; if (upc !== 10'd12 || addr_err !== 1'b1) begin
      errors++; $display("FAIL mid_run_pre got upc=%0d aerr=%b exp upc=12 aerr=1", upc, addr_err); end
    reset = 1'b0;
    #2;
    checks++; if (upc !== 10'd0 || uword !== 26'd0 || uword_valid !== 1'b0 || addr_err !== 1'b0) begin
      errors++; $display("FAIL mid_run_reset got upc=%0d uw=%h v=%b aerr=%b exp 0 0 0 0", upc, uword, uword_valid, addr_err); end
    reset = 1'b1;
    tick();
    checks++; if (uword_valid !== 1'b0) begin errors++; $display("FAIL restart_prime got=%b exp=0", uword_valid); end
    tick();
    checks++; if (uword_valid !== 1'b1 || upc !== 10'd0 || uword !== w0) begin
      errors++; $display("FAIL restart_first got v=%b upc=%0d uw=%h exp v=1 upc=0 uw=%h", uword_valid, upc, uword, w0); end
    tick();
    checks++; if (upc !== 10'd10) begin errors++; $display("FAIL restart_jump got=%0d exp=10", upc); end
    halt();
  endtask

  initial begin
    test_reset();
    test_linear();
    test_branch();
    test_wide();
    test_call_return();
    test_stall_load();
    test_addr_err();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/useq_control_store.md
Name: useq_control_store

Overview:
- Parametrised microprogram sequencer with a writable control store. It is the next generation of the fixed 26-bit microcode ROM.
- Holds microwords and an opcode map RAM (normal and wide pages). Keeps a registered micro-PC, evaluates branch, call, return, fetch and map sequencing, and drives a registered microword to the stack-machine datapath.
- Microword layout, MSB first: ctrl[CTRL_W], seq[3], cond[3], next[ADDR_W].

Parameters:
- ADDR_W, 10, micro-address width.
- DEPTH, 301, control-store entries; any value up to 2^ADDR_W.
- CTRL_W, 10, datapath control field width. WORD_W = CTRL_W+6+ADDR_W, which is 26.
- OPC_W, 8, opcode width. Constraint: OPC_W+1 <= ADDR_W.
- STK_D, 4, micro-return stack depth, 1..16.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = sequence, 0 = halt and allow loading.
- stall  in  1  hold all state for this cycle (RUN state only).
- opcode  in  OPC_W  current IR opcode, used by MAP.
- flag_z, flag_n, flag_c, flag_v  in  1 each  datapath condition flags.
- wr_en  in  1  load strobe.
- wr_sel  in  1  0 = control store, 1 = map RAM.
- wr_addr  in  ADDR_W  load address. For the map RAM, index = {wide, opcode}.
- wr_data  in  WORD_W  load data. The map RAM uses the low ADDR_W bits.
- err_clr  in  1  clears the sticky errors.
- uword  out  WORD_W  registered current microword.
- ctrl  out  CTRL_W  equals uword[WORD_W-1 -: CTRL_W].
- uword_valid  out  1  uword is live.
- upc  out  ADDR_W  address of uword.
- fetch_start  out  1  one-cycle pulse: a FETCH was just taken.
- wide_active  out  1  wide prefix pending.
- stk_ovf, stk_unf, addr_err, wr_err  out  1 each  sticky errors.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - upc=0, uword=0, uword_valid=0, stack empty, wide_active=0, fetch_start=0, all errors 0, state HALT.
  - Store and map contents are not cleared.
- State machine: HALT, PRIME, RUN.
  - HALT, run=1: go to PRIME. Otherwise stay; uword_valid=0.
  - PRIME: uword<=store[upc], uword_valid<=1, go to RUN. upc does not advance. Latency from run rising to the first valid word is 2 clocks.
  - RUN, run=0: go to HALT; upc held, uword_valid<=0.
  - RUN, stall=1: nothing changes.
  - RUN otherwise: upc<=nxt and uword<=store[nxt] in the same edge. One microword per clock.
- cond selects: 000 Z, 001 N, 010 C, 011 V, 100 !Z, 101 !N, 110 true, 111 false. Flags are sampled in the cycle the word is displayed.
- seq determines nxt:
  - 000 INC: upc+1.
  - 001 BR: next if cond true, else upc+1.
  - 010 JMP: next.
  - 011 CALL: push upc+1, then next.
  - 100 RET: pop.
  - 101: treated as INC.
  - 110 FETCH: nxt=0 and fetch_start pulses next cycle. If cond=111, also set wide_active.
  - 111 MAP: map[{wide_active, opcode}], then clear wide_active.
- Wrap: INC/BR from DEPTH-1 goes to 0. No error.
- Any computed nxt >= DEPTH: nxt=0 instead, addr_err set.
- CALL with stack full: jump still taken, push dropped, stk_ovf set.
- RET with stack empty: nxt=0, stk_unf set.
- Loading:
  - wr_en in HALT writes at the clock edge.
  - wr_en in PRIME or RUN is ignored and sets wr_err.
  - A control-store wr_addr >= DEPTH is ignored and sets wr_err.
- Errors stay set until err_clr or reset. If err_clr and a new error occur in the same cycle, the error wins.

Test Plan:
- Linear fetch: load store[0..3] with seq INC, INC, INC, then MAP; map[{0,0x60}]=4; opcode=0x60; run=1 -> valid at cycle 2; upc 0,1,2,3,4; uword tracks the store.
- Conditional branch: store[44] = BR cond=000 next=47. flag_z=1 -> upc 47. flag_z=0 -> upc 45.
- Wide prefix: store[152] = FETCH cond=111. Then opcode 0x15 with map[{1,0x15}]=75 and map[{0,0x15}]=86 -> wide path reaches 75 and wide_active clears; the following non-wide instruction reaches 86; fetch_start pulses once per FETCH.
- Call/return: nested CALLs to depth STK_D+1 -> stk_ovf=1 and the last jump is still taken. RETs unwind to the correct addresses; the extra RET goes to 0 with stk_unf=1.
- Stall/halt/load: stall held 3 cycles -> upc and uword frozen. wr_en while running -> wr_err=1 and the store is unchanged. run=0 then a write to 300 -> takes effect; after PRIME, word 300 appears.
- Reset mid-run: assert reset at upc=12 -> all outputs reach their reset values asynchronously; after release with run=1, execution restarts at 0.
